// File: rtl/recv_frame_bram_if.sv
// recv_frame_bram_if: AXI-Stream input and BRAM write bus of the frame receiver
//   s_tdata/s_tvalid/s_tlast/s_tready : AXIS beat {im, re}, re in the low half
//   bram_data/bram_addr/bram_we       : registered BRAM write port
//   master modport = stream source / BRAM sink, slave modport = receiver
interface recv_frame_bram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic                s_tlast;
  logic [2*DATA_W-1:0] bram_data;
  logic [ADDR_W-1:0]   bram_addr;
  logic                bram_we;
  modport master (output s_tdata, s_tvalid, s_tlast, input s_tready, bram_data, bram_addr, bram_we);
  modport slave  (input s_tdata, s_tvalid, s_tlast, output s_tready, bram_data, bram_addr, bram_we);
endinterface

// File: rtl/recv_frame_bram.sv
// recv_frame_bram: receives one complex AXIS frame of run-time length into a BRAM
//   aclk, areset (async, active-high)
//   n_len/conj/rev/start : frame request, sampled on an accepted start
//   busy/done/err_len    : status; err_len is sticky until the next accepted start
//   s                    : AXIS input and registered BRAM write port (slave modport)
//   RECV_FRAME_SAT_EN    : when defined, conjugation saturates instead of wrapping
module recv_frame_bram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] n_len,
  input  logic              conj,
  input  logic              rev,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  recv_frame_bram_if.slave  s
);
  typedef enum logic {IDLE, READ} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, n_len_q, n_len_d, addr_q, addr_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic conj_q, conj_d, rev_q, rev_d, err_q, err_d, done_q, done_d, we_q, we_d;
  logic last;
  logic signed [DATA_W-1:0] im, im_neg;
  assign im = s.s_tdata[2*DATA_W-1:DATA_W];
`ifdef RECV_FRAME_SAT_EN
  // -(-2^(W-1)) is not representable; clamp to the largest positive value
  assign im_neg = (im == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} : -im;
`else
  assign im_neg = -im;
`endif
  assign last = idx_q == n_len_q - 1'b1;
  assign s.s_tready = state_q == READ;
  assign busy = state_q == READ;
  assign done = done_q;
  assign err_len = err_q;
  assign s.bram_we = we_q;
  assign s.bram_addr = addr_q;
  assign s.bram_data = data_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    n_len_d = n_len_q;
    conj_d = conj_q;
    rev_d = rev_q;
    err_d = err_q;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    we_d = 1'b0;
    if (state_q == IDLE && start) begin
      if (n_len != '0) begin
        n_len_d = n_len;
        conj_d = conj;
        rev_d = rev;
        err_d = 1'b0;
        idx_d = '0;
        state_d = READ;
      end else begin
        err_d = 1'b1;
        done_d = 1'b1;
      end
    end
    if (state_q == READ && s.s_tvalid) begin
      we_d = 1'b1;
      addr_d = rev_q ? n_len_q - 1'b1 - idx_q : idx_q;
      data_d = {conj_q ? im_neg : im, s.s_tdata[DATA_W-1:0]};
      idx_d = idx_q + 1'b1;
      // tlast is only checked; the frame always runs to n_len_q beats
      if (s.s_tlast != last) err_d = 1'b1;
      if (last) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      idx_q <= '0;
      n_len_q <= '0;
      conj_q <= 1'b0;
      rev_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      n_len_q <= n_len_d;
      conj_q <= conj_d;
      rev_q <= rev_d;
      err_q <= err_d;
      done_q <= done_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_recv_frame_bram.sv
// tb_recv_frame_bram: scoreboard bench for recv_frame_bram against a frame-level model
module tb_recv_frame_bram;
  localparam int DW = 16;
  localparam int AW = 13;
  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic [AW-1:0] n_len = '0;
  logic conj = 1'b0, rev = 1'b0, start = 1'b0;
  logic busy, done, err_len;
  bit armed = 1'b0;
  int checks = 0, passed = 0;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [2*DW-1:0] data;
    logic          done;
  } exp_t;
  exp_t sb[$];
  logic [2*DW-1:0] beats[$];
  recv_frame_bram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  recv_frame_bram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .aclk(aclk), .areset(areset), .n_len(n_len), .conj(conj), .rev(rev), .start(start),
    .busy(busy), .done(done), .err_len(err_len), .s(bus)
  );
  always #5 aclk = ~aclk;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [DW-1:0] neg_im(logic [DW-1:0] im);
    int v;
    logic [31:0] t;
    v = -int'($signed(im));
`ifdef RECV_FRAME_SAT_EN
    if (v > (1 << (DW-1)) - 1) v = (1 << (DW-1)) - 1;
`endif
    t = v;
    return t[DW-1:0];
  endfunction
  always @(negedge aclk) begin : monitor
    exp_t e;
    if (armed && !areset && (bus.bram_we || done)) begin
      if (sb.size() == 0) check("unexpected_output", {62'd0, bus.bram_we, done}, 64'd0);
      else begin
        e = sb.pop_front();
        check("bram_we", bus.bram_we, e.we);
        if (e.we) begin
          check("bram_addr", bus.bram_addr, e.addr);
          check("bram_data", bus.bram_data, e.data);
        end
        check("done", done, e.done);
      end
    end
  end
  task automatic run_frame(int n, bit cj, bit rv, int vmode, int bad, int abort_after);
    int i, k;
    bit v, tl, exp_err;
    logic [2*DW-1:0] b;
    i = 0;
    k = 0;
    exp_err = 1'b0;
    n_len = n[AW-1:0];
    conj = cj;
    rev = rv;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("err_clear_on_start", err_len, 0);
    check("busy_in_read", busy, 1);
    while (i < n) begin
      if (i == abort_after) begin
        bus.s_tvalid = 1'b0;
        @(negedge aclk); #1;
        areset = 1'b1;
        #1;
        check("rst_bram_we", bus.bram_we, 0);
        check("rst_bram_addr", bus.bram_addr, 0);
        check("rst_bram_data", bus.bram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_tready", bus.s_tready, 0);
        check("rst_done", done, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        return;
      end
      v = vmode == 0 ? 1'b1 : vmode == 1 ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      if (v) begin
        b = beats[i];
        tl = (i == n-1) ^ (i == bad);
        if (tl != (i == n-1)) exp_err = 1'b1;
        check("tready", bus.s_tready, 1);
        bus.s_tdata = b;
        bus.s_tlast = tl;
        bus.s_tvalid = 1'b1;
        sb.push_back('{we: 1'b1, addr: AW'(rv ? n-1-i : i),
                       data: {cj ? neg_im(b[2*DW-1:DW]) : b[2*DW-1:DW], b[DW-1:0]},
                       done: i == n-1});
        i++;
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata = $urandom;
        bus.s_tlast = 1'($urandom);
      end
      @(posedge aclk); #1;
      k++;
    end
    bus.s_tvalid = 1'b0;
    check("err_len_end", err_len, exp_err);
    check("busy_after_frame", busy, 0);
  endtask
  task automatic run_zero();
    n_len = '0;
    start = 1'b1;
    sb.push_back('{we: 1'b0, addr: '0, data: '0, done: 1'b1});
    @(posedge aclk); #1;
    start = 1'b0;
    check("zero_err_len", err_len, 1);
    check("zero_busy", busy, 0);
    @(posedge aclk); #1;
  endtask
  task automatic fill_seq(int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back({16'(10*(i+1)), 16'(i+1)});
  endtask
  task automatic fill_rand(int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back($urandom);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.s_tdata = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
    #2 areset = 1'b1;
    #10;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_len, 0);
    check("reset_tready", bus.s_tready, 0);
    check("reset_we", bus.bram_we, 0);
    check("reset_addr", bus.bram_addr, 0);
    check("reset_data", bus.bram_data, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    armed = 1'b1;
    @(posedge aclk); #1;
    fill_seq(4);
    run_frame(4, 1, 1, 0, -1, -1);
    run_frame(4, 0, 0, 1, -1, -1);
    beats.delete();
    beats.push_back(32'h8000_0005);
    run_frame(1, 1, 1, 0, -1, -1);
    beats.delete();
    beats.push_back(32'h8000_0001);
    beats.push_back(32'h7FFF_0002);
    run_frame(2, 1, 0, 0, -1, -1);
    fill_seq(3);
    run_frame(3, 0, 0, 0, 1, -1);
    fill_seq(2);
    run_frame(2, 0, 1, 0, -1, -1);
    @(posedge aclk); #1;
    run_zero();
    fill_rand(8);
    run_frame(8, 0, 0, 0, -1, 2);
    check("sb_empty_after_abort", sb.size(), 0);
    fill_rand(8);
    run_frame(8, 1, 1, 2, -1, -1);
    for (int t = 0; t < 30; t++) begin
      int n, bad;
      n = $urandom_range(1, 12);
      bad = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, n-1)) : -1;
      fill_rand(n);
      run_frame(n, 1'($urandom), 1'($urandom), 2, bad, -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk); #1;
      end
    end
    repeat (3) @(posedge aclk);
    #1;
    check("sb_empty_at_end", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
